// File: rtl/histogram_pkg.sv
// Shared definitions for the histogram controller: state encoding, default
// geometry and the memory word width.
package histogram_pkg;

    localparam int DEFAULT_PIXELS_PER_FETCH = 32;
    localparam int DEFAULT_NUM_FETCHES      = 32;
    localparam int WORD_W                   = 128;
    localparam int TIMER_W                  = 3;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        RD_IN    = 4'd1,
        WAIT_IN  = 4'd2,
        DATA_IN  = 4'd3,
        RD_SCR   = 4'd4,
        WAIT_SCR = 4'd5,
        DATA_SCR = 4'd6,
        WR       = 4'd7,
        SHIFT    = 4'd8,
        DONE     = 4'd9
    } state_t;

endpackage

// File: rtl/histogram_control_if.sv
// Handshake and memory-strobe bundle between the histogram controller and
// its environment; the controller takes the slave side.
interface histogram_control_if;

    logic        dut_run;
    logic        dut_busy;
    logic        dut_done;
    logic        set_read_address_input_mem;
    logic        read_data_ready_input_mem;
    logic        set_read_address_scratch_mem;
    logic        read_data_ready_scratch_mem;
    logic        set_write_address_scratch_mem;
    logic        shift_scratch_memory_rw_address;
    logic [31:0] perf_cycles;

    modport master (
        output dut_run,
        input  dut_busy, dut_done,
        input  set_read_address_input_mem, read_data_ready_input_mem,
        input  set_read_address_scratch_mem, read_data_ready_scratch_mem,
        input  set_write_address_scratch_mem, shift_scratch_memory_rw_address,
        input  perf_cycles
    );

    modport slave (
        input  dut_run,
        output dut_busy, dut_done,
        output set_read_address_input_mem, read_data_ready_input_mem,
        output set_read_address_scratch_mem, read_data_ready_scratch_mem,
        output set_write_address_scratch_mem, shift_scratch_memory_rw_address,
        output perf_cycles
    );

endinterface

// File: rtl/hist_wait_timer.sv
// Memory-latency countdown shared by both wait states; loading it in the read
// state makes the following wait state last exactly MEM_LATENCY cycles.
module hist_wait_timer
    import histogram_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic i_load,
    output logic o_expired
);

    logic [TIMER_W-1:0] r_count;

    // Countdown register: reload on a read issue, then count down to zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= {TIMER_W{1'b0}};
        end else if (i_load) begin
            r_count <= TIMER_W'(MEM_LATENCY - 1);
        end else if (r_count != {TIMER_W{1'b0}}) begin
            r_count <= r_count - TIMER_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expired = (r_count == {TIMER_W{1'b0}});

endmodule

// File: rtl/histogram_control.sv
// Histogram controller: sequences input fetches and per-pixel scratch
// read-modify-write strobes. Define HIST_CTRL_PERF_EN for the busy-cycle counter.
module histogram_control
    import histogram_pkg::*;
#(
    parameter int NUM_FETCHES      = DEFAULT_NUM_FETCHES,
    parameter int PIXELS_PER_FETCH = DEFAULT_PIXELS_PER_FETCH,
    parameter int MEM_LATENCY      = 1
) (
    input  logic               clock,
    input  logic               reset,
    histogram_control_if.slave bus
);

    localparam int PIX_W   = $clog2(PIXELS_PER_FETCH) + 1;
    localparam int FETCH_W = $clog2(NUM_FETCHES) + 1;
    localparam logic [PIX_W-1:0]   PIX_LAST   = PIX_W'(PIXELS_PER_FETCH - 1);
    localparam logic [FETCH_W-1:0] FETCH_LAST = FETCH_W'(NUM_FETCHES - 1);

    state_t             r_state;
    logic [PIX_W-1:0]   r_pix_cnt;
    logic [FETCH_W-1:0] r_fetch_cnt;
    logic r_busy, r_done, r_in_rd, r_in_rdy, r_scr_rd, r_scr_rdy, r_scr_wr, r_shift;
    logic w_timer_load, w_timer_expired;

    assign w_timer_load = (r_state == RD_IN) || (r_state == RD_SCR);

    hist_wait_timer #(.MEM_LATENCY(MEM_LATENCY)) u_wait_timer (
        .clock     (clock),
        .reset     (reset),
        .i_load    (w_timer_load),
        .o_expired (w_timer_expired)
    );

    // Sequencer: each branch sets the next state and the one-hot strobe that state owns.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pix_cnt   <= {PIX_W{1'b0}};
            r_fetch_cnt <= {FETCH_W{1'b0}};
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_in_rd     <= 1'b0;
            r_in_rdy    <= 1'b0;
            r_scr_rd    <= 1'b0;
            r_scr_rdy   <= 1'b0;
            r_scr_wr    <= 1'b0;
            r_shift     <= 1'b0;
        end else begin
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_in_rd   <= 1'b0;
            r_in_rdy  <= 1'b0;
            r_scr_rd  <= 1'b0;
            r_scr_rdy <= 1'b0;
            r_scr_wr  <= 1'b0;
            r_shift   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.dut_run) begin
                        r_state     <= RD_IN;
                        r_in_rd     <= 1'b1;
                        r_fetch_cnt <= {FETCH_W{1'b0}};
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                RD_IN: r_state <= WAIT_IN;
                WAIT_IN: begin
                    if (w_timer_expired) begin
                        r_state  <= DATA_IN;
                        r_in_rdy <= 1'b1;
                    end else begin
                        r_state <= WAIT_IN;
                    end
                end
                DATA_IN: begin
                    r_state   <= RD_SCR;
                    r_scr_rd  <= 1'b1;
                    r_pix_cnt <= {PIX_W{1'b0}};
                end
                RD_SCR: r_state <= WAIT_SCR;
                WAIT_SCR: begin
                    if (w_timer_expired) begin
                        r_state   <= DATA_SCR;
                        r_scr_rdy <= 1'b1;
                    end else begin
                        r_state <= WAIT_SCR;
                    end
                end
                DATA_SCR: begin
                    r_state  <= WR;
                    r_scr_wr <= 1'b1;
                end
                WR: begin
                    r_state <= SHIFT;
                    r_shift <= 1'b1;
                end
                SHIFT: begin
                    // SHIFT sits between the write and the next read so a repeated bin sees its update.
                    r_pix_cnt <= r_pix_cnt + PIX_W'(1);
                    if (r_pix_cnt != PIX_LAST) begin
                        r_state  <= RD_SCR;
                        r_scr_rd <= 1'b1;
                    end else if (r_fetch_cnt != FETCH_LAST) begin
                        r_state     <= RD_IN;
                        r_in_rd     <= 1'b1;
                        r_fetch_cnt <= r_fetch_cnt + FETCH_W'(1);
                    end else begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dut_busy                        = r_busy;
    assign bus.dut_done                        = r_done;
    assign bus.set_read_address_input_mem      = r_in_rd;
    assign bus.read_data_ready_input_mem       = r_in_rdy;
    assign bus.set_read_address_scratch_mem    = r_scr_rd;
    assign bus.read_data_ready_scratch_mem     = r_scr_rdy;
    assign bus.set_write_address_scratch_mem   = r_scr_wr;
    assign bus.shift_scratch_memory_rw_address = r_shift;

`ifdef HIST_CTRL_PERF_EN
    logic        w_run_accept;
    logic [31:0] r_perf_cycles;

    assign w_run_accept = (r_state == IDLE) && bus.dut_run;

    // Busy-cycle counter: cleared by an accepted start, saturating, frozen while idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_perf_cycles <= 32'd0;
        end else if (w_run_accept) begin
            r_perf_cycles <= 32'd0;
        end else if (r_busy && (r_perf_cycles != 32'hFFFF_FFFF)) begin
            r_perf_cycles <= r_perf_cycles + 32'd1;
        end else begin
            r_perf_cycles <= r_perf_cycles;
        end
    end

    assign bus.perf_cycles = r_perf_cycles;
`else
    assign bus.perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_histogram_control.sv
// Bench for histogram_control: three differently-parameterised instances, a
// per-cycle strobe-sequence model, and hand-computed latency/count checks.
module tb_histogram_control;

`ifdef HIST_CTRL_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    // Bit order: busy, done, in_rd, in_rdy, scr_rd, scr_rdy, scr_wr, shift
    localparam logic [7:0] E_WAIT    = 8'b1000_0000;
    localparam logic [7:0] E_DONE    = 8'b1100_0000;
    localparam logic [7:0] E_IN_RD   = 8'b1010_0000;
    localparam logic [7:0] E_IN_RDY  = 8'b1001_0000;
    localparam logic [7:0] E_SCR_RD  = 8'b1000_1000;
    localparam logic [7:0] E_SCR_RDY = 8'b1000_0100;
    localparam logic [7:0] E_SCR_WR  = 8'b1000_0010;
    localparam logic [7:0] E_SHIFT   = 8'b1000_0001;

    typedef struct {
        int done_at;
        int n_done;
        int c_in_rd;
        int c_scr_rd;
        int c_scr_rdy;
        int c_scr_wr;
        int c_shift;
        int gap_in;
        int gap_scr;
        logic [7:0] after_abort;
    } meas_t;

    logic clk;
    logic run [3];
    logic rst [3];
    logic chk_en;
    int   n_checks;
    int   n_fail;

    int nf [3] = '{32, 1, 2};
    int pp [3] = '{32, 32, 4};
    int ml [3] = '{1, 1, 3};

    logic [7:0]  exp_q [3][$];
    int          exp_perf [3];
    logic [7:0]  act [3];
    logic [31:0] act_perf [3];

    histogram_control_if if_a ();
    histogram_control_if if_b ();
    histogram_control_if if_c ();

    assign if_a.dut_run = run[0];
    assign if_b.dut_run = run[1];
    assign if_c.dut_run = run[2];

    histogram_control u_dut_a (.clock(clk), .reset(rst[0]), .bus(if_a));
    histogram_control #(.NUM_FETCHES(1)) u_dut_b (.clock(clk), .reset(rst[1]), .bus(if_b));
    histogram_control #(.NUM_FETCHES(2), .PIXELS_PER_FETCH(4), .MEM_LATENCY(3))
        u_dut_c (.clock(clk), .reset(rst[2]), .bus(if_c));

    assign act[0] = {if_a.dut_busy, if_a.dut_done, if_a.set_read_address_input_mem,
                     if_a.read_data_ready_input_mem, if_a.set_read_address_scratch_mem,
                     if_a.read_data_ready_scratch_mem, if_a.set_write_address_scratch_mem,
                     if_a.shift_scratch_memory_rw_address};
    assign act[1] = {if_b.dut_busy, if_b.dut_done, if_b.set_read_address_input_mem,
                     if_b.read_data_ready_input_mem, if_b.set_read_address_scratch_mem,
                     if_b.read_data_ready_scratch_mem, if_b.set_write_address_scratch_mem,
                     if_b.shift_scratch_memory_rw_address};
    assign act[2] = {if_c.dut_busy, if_c.dut_done, if_c.set_read_address_input_mem,
                     if_c.read_data_ready_input_mem, if_c.set_read_address_scratch_mem,
                     if_c.read_data_ready_scratch_mem, if_c.set_write_address_scratch_mem,
                     if_c.shift_scratch_memory_rw_address};
    assign act_perf[0] = if_a.perf_cycles;
    assign act_perf[1] = if_b.perf_cycles;
    assign act_perf[2] = if_c.perf_cycles;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_int(input string name, input longint got, input longint expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    // The whole image as the ordered list of per-cycle strobe patterns.
    task automatic push_image(input int i);
        for (int f = 0; f < nf[i]; f++) begin
            exp_q[i].push_back(E_IN_RD);
            for (int w = 0; w < ml[i]; w++) exp_q[i].push_back(E_WAIT);
            exp_q[i].push_back(E_IN_RDY);
            for (int p = 0; p < pp[i]; p++) begin
                exp_q[i].push_back(E_SCR_RD);
                for (int w = 0; w < ml[i]; w++) exp_q[i].push_back(E_WAIT);
                exp_q[i].push_back(E_SCR_RDY);
                exp_q[i].push_back(E_SCR_WR);
                exp_q[i].push_back(E_SHIFT);
            end
        end
        exp_q[i].push_back(E_DONE);
    endtask

    // Compare process: every instance, every cycle, against the model.
    always @(negedge clk) begin
        logic [7:0]  e;
        logic [31:0] ep;
        bit          was_idle;
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                was_idle = (exp_q[i].size() == 0);
                e  = was_idle ? 8'h00 : exp_q[i].pop_front();
                ep = PERF_EN ? 32'(exp_perf[i]) : 32'd0;
                n_checks++;
                if (act[i] !== e) begin
                    n_fail++;
                    $display("FAIL strobes inst%0d t=%0t: got %b expected %b", i, $time, act[i], e);
                end
                n_checks++;
                if (act_perf[i] !== ep) begin
                    n_fail++;
                    $display("FAIL perf inst%0d t=%0t: got %0d expected %0d", i, $time, act_perf[i], ep);
                end
                if (rst[i]) begin
                    exp_q[i].delete();
                    exp_perf[i] = 0;
                end else if (was_idle && run[i]) begin
                    push_image(i);
                    exp_perf[i] = 0;
                end else if (!was_idle) begin
                    exp_perf[i] = exp_perf[i] + 1;
                end else begin
                    exp_perf[i] = exp_perf[i];
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_image(input int i, input int hold, input int budget,
                             input bit pulse_in_done, input int abort_at, output meas_t m);
        logic [7:0] a;
        int last_in, last_scr;
        m = '{default: 0};
        m.after_abort = 8'hFF;
        m.gap_in = -1;
        m.gap_scr = -1;
        last_in = 0;
        last_scr = 0;
        run[i] = 1'b1;
        for (int n = 1; n <= budget; n++) begin
            cyc();
            a = act[i];
            if (n >= hold) run[i] = 1'b0;
            if (n == abort_at) rst[i] = 1'b1;
            if (n == abort_at + 1) begin
                rst[i] = 1'b0;
                m.after_abort = a;
            end
            if (a[5]) begin m.c_in_rd++; last_in = n; end
            if (a[4] && m.gap_in < 0) m.gap_in = n - last_in;
            if (a[3]) begin m.c_scr_rd++; last_scr = n; end
            if (a[2]) begin
                m.c_scr_rdy++;
                if (m.gap_scr < 0) m.gap_scr = n - last_scr;
            end
            if (a[1]) m.c_scr_wr++;
            if (a[0]) m.c_shift++;
            if (a[6]) begin
                m.n_done++;
                if (m.n_done == 1) m.done_at = n;
                if (pulse_in_done) run[i] = 1'b1;
            end
        end
        run[i] = 1'b0;
    endtask

    initial begin
        meas_t m;
        n_checks = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run[i] = 1'b0;
            rst[i] = 1'b1;
            exp_perf[i] = 0;
        end
        repeat (3) cyc();
        chk_en = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        cyc();
        check_int("reset_outputs", act[0], 0);
        check_int("reset_perf", act_perf[0], 0);

        run_image(1, 1, 300, 1'b0, -10, m);
        check_int("b_done_latency", m.done_at, 164);
        check_int("b_done_count", m.n_done, 1);
        check_int("b_in_rd_count", m.c_in_rd, 1);
        check_int("b_scr_rd_count", m.c_scr_rd, 32);
        check_int("b_scr_rdy_count", m.c_scr_rdy, 32);
        check_int("b_scr_wr_count", m.c_scr_wr, 32);
        check_int("b_shift_count", m.c_shift, 32);
        check_int("b_perf_after_done", act_perf[1], PERF_EN ? 164 : 0);

        run_image(1, 10, 400, 1'b1, -10, m);
        check_int("b_held_run_done_count", m.n_done, 1);
        check_int("b_held_run_latency", m.done_at, 164);
        check_int("b_held_run_in_rd", m.c_in_rd, 1);

        run_image(1, 1, 300, 1'b0, 50, m);
        check_int("b_abort_outputs", m.after_abort, 0);
        check_int("b_abort_no_done", m.n_done, 0);
        run_image(1, 1, 300, 1'b0, -10, m);
        check_int("b_restart_latency", m.done_at, 164);

        run_image(2, 1, 150, 1'b0, -10, m);
        check_int("c_in_gap", m.gap_in, 4);
        check_int("c_scr_gap", m.gap_scr, 4);
        check_int("c_done_latency", m.done_at, 67);
        check_int("c_in_rd_count", m.c_in_rd, 2);

        run_image(0, 1, 5300, 1'b0, -10, m);
        check_int("a_done_latency", m.done_at, 5217);
        check_int("a_done_count", m.n_done, 1);
        check_int("a_scr_wr_count", m.c_scr_wr, 1024);

        repeat (2) cyc();
        for (int i = 0; i < 3; i++) check_int("model_drained", exp_q[i].size(), 0);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
